// File: rtl/sym_pwl_pkg.sv
// Shared widths, saturation limits and coefficient layout for the symmetric PWL evaluator.
package sym_pwl_pkg;
    localparam int M         = 4;
    localparam int N         = 8;
    localparam int SEG_BITS  = 3;
    localparam int SYM_CONST = 256;

    localparam int W      = M + N;
    localparam int MAG_W  = M + N - 1;
    localparam int PROD_W = 2 * W;
    localparam int SEGS   = 1 << SEG_BITS;
    localparam int SYM_ONE = 1 << N;

    typedef logic signed [W-1:0] sample_t;

    localparam sample_t SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam sample_t SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        sample_t slope;
        sample_t icpt;
    } coef_t;
endpackage

// File: rtl/sym_pwl_coef_ram.sv
// Per-segment slope/intercept register file: one synchronous write port, one
// combinational read port (a same-cycle write is seen only from the next cycle).
module sym_pwl_coef_ram
    import sym_pwl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [SEG_BITS-1:0] waddr,
    input  coef_t               wdata,
    input  logic [SEG_BITS-1:0] raddr,
    output coef_t               rdata
);
    coef_t mem_q [SEGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/sym_pwl_eval.sv
// Folds a signed sample to |x| and evaluates a programmable PWL on it; 3-cycle valid/ready
// pipeline, bubbles collapse, output held under stall. SYM_PWL_ROUND_EN: round half-up before the shift.
module sym_pwl_eval
    import sym_pwl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    input  logic                cfg_we,
    input  logic [SEG_BITS-1:0] cfg_addr,
    input  logic [W-1:0]        cfg_slope,
    input  logic [W-1:0]        cfg_icpt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        f_out,
    output logic [W-1:0]        s_out,
    output logic                sign_out
);
    localparam int SH_W = PROD_W - N;

    logic             s1_vld_q, s1_vld_d, s1_sign_q, s1_sign_d;
    logic [MAG_W-1:0] s1_mag_q, s1_mag_d;
    logic             s2_vld_q, s2_vld_d, s2_sign_q, s2_sign_d;
    logic [MAG_W-1:0] s2_mag_q, s2_mag_d;
    coef_t            s2_coef_q, s2_coef_d;
    logic             s3_vld_q, s3_vld_d, s3_sign_q, s3_sign_d;
    sample_t          s3_f_q, s3_f_d;

    logic             s2_acc, s3_acc;
    logic [W-1:0]     abs_full;
    logic [MAG_W-1:0] fold_mag;
    coef_t            rd_coef;

    logic signed [PROD_W-1:0] prod, prod_adj;
    logic signed [SH_W-1:0]   shifted;
    logic signed [SH_W:0]     y_wide;
    sample_t                  y_clamp;

    assign s3_acc   = !s3_vld_q || out_ready;
    assign s2_acc   = !s2_vld_q || s3_acc;
    assign in_ready = !s1_vld_q || s2_acc;

    // Only -2^(W-1) leaves bit W-1 set after negation; it saturates to the largest magnitude.
    assign abs_full = in_data[W-1] ? (~in_data) + W'(1) : in_data;
    assign fold_mag = abs_full[W-1] ? {MAG_W{1'b1}} : abs_full[MAG_W-1:0];

    sym_pwl_coef_ram u_coef_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata ({cfg_slope, cfg_icpt}),
        .raddr (s1_mag_q[MAG_W-1 -: SEG_BITS]),
        .rdata (rd_coef)
    );

    assign prod = PROD_W'(s2_coef_q.slope) * PROD_W'($signed({1'b0, s2_mag_q}));
`ifdef SYM_PWL_ROUND_EN
    assign prod_adj = prod + PROD_W'(SYM_ONE >> 1);
`else
    assign prod_adj = prod;
`endif
    assign shifted = $signed(prod_adj[PROD_W-1:N]);
    assign y_wide  = (SH_W+1)'(shifted) + (SH_W+1)'(s2_coef_q.icpt);

    always_comb begin
        y_clamp = y_wide[W-1:0];
        if (y_wide > (SH_W+1)'(SAT_MAX)) begin
            y_clamp = SAT_MAX;
        end else if (y_wide < (SH_W+1)'(SAT_MIN)) begin
            y_clamp = SAT_MIN;
        end
    end

    // Data registers load only with a valid sample so a stalled or idle output stays put.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_sign_d = s1_sign_q;
        s1_mag_d  = s1_mag_q;
        s2_vld_d  = s2_vld_q;
        s2_sign_d = s2_sign_q;
        s2_mag_d  = s2_mag_q;
        s2_coef_d = s2_coef_q;
        s3_vld_d  = s3_vld_q;
        s3_sign_d = s3_sign_q;
        s3_f_d    = s3_f_q;
        if (in_ready) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_data[W-1];
                s1_mag_d  = fold_mag;
            end
        end
        if (s2_acc) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_sign_d = s1_sign_q;
                s2_mag_d  = s1_mag_q;
                s2_coef_d = rd_coef;
            end
        end
        if (s3_acc) begin
            s3_vld_d = s2_vld_q;
            if (s2_vld_q) begin
                s3_sign_d = s2_sign_q;
                s3_f_d    = y_clamp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_mag_q  <= '0;
            s2_coef_q <= '0;
            s3_vld_q  <= 1'b0;
            s3_sign_q <= 1'b0;
            s3_f_q    <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_sign_q <= s1_sign_d;
            s1_mag_q  <= s1_mag_d;
            s2_vld_q  <= s2_vld_d;
            s2_sign_q <= s2_sign_d;
            s2_mag_q  <= s2_mag_d;
            s2_coef_q <= s2_coef_d;
            s3_vld_q  <= s3_vld_d;
            s3_sign_q <= s3_sign_d;
            s3_f_q    <= s3_f_d;
        end
    end

    assign out_valid = s3_vld_q;
    assign f_out     = s3_f_q;
    assign sign_out  = s3_sign_q;
    assign s_out     = s3_vld_q ? W'(SYM_CONST) : '0;
endmodule

// File: tb/tb_sym_pwl_eval.sv
// Directed bench for sym_pwl_eval with hand-computed expected results.
module tb_sym_pwl_eval;
    import sym_pwl_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid, in_ready;
    logic [W-1:0]        in_data;
    logic                cfg_we;
    logic [SEG_BITS-1:0] cfg_addr;
    logic [W-1:0]        cfg_slope, cfg_icpt;
    logic                out_valid, out_ready;
    logic [W-1:0]        f_out, s_out;
    logic                sign_out;

    int n_chk  = 0;
    int n_pass = 0;

    sym_pwl_eval dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_slope (cfg_slope),
        .cfg_icpt  (cfg_icpt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out),
        .s_out     (s_out),
        .sign_out  (sign_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic write_coef(input int addr, input int slope, input int icpt);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = addr[SEG_BITS-1:0];
        cfg_slope = slope[W-1:0];
        cfg_icpt  = icpt[W-1:0];
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic run_one(input string tag, input int x, input int exp_f, input int exp_sign);
        int lat;
        bit found;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = x[W-1:0];
        check({tag, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat   = 0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid) found = 1'b1;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_f_out"}, int'($signed(f_out)), exp_f);
        check({tag, "_sign_out"}, int'(sign_out), exp_sign);
        check({tag, "_s_out"}, int'(s_out), SYM_CONST);
    endtask

    int bp_x[6]    = '{5, -6, 7, -8, 9, -10};
    int got_f[$];
    int got_s[$];
    int sent, stalled_f, ov_count;
    bit fire_in;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_slope = '0; cfg_icpt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_f_out", int'(f_out), 0);
        check("rst_s_out", int'(s_out), 0);
        check("rst_sign_out", int'(sign_out), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        // Basic fold: 128*64/256 + 128 = 160 for both signs.
        write_coef(0, 64, 128);
        run_one("fold_pos", 128, 160, 0);
        run_one("fold_neg", -128, 160, 1);

        // Most negative input saturates to magnitude 2047, segment 7.
        write_coef(7, 0, 100);
        run_one("sat_min", -2048, 100, 1);

        // 1*128 = 128 -> 0.5 LSB after the shift.
        write_coef(0, 1, 0);
`ifdef SYM_PWL_ROUND_EN
        run_one("round", 128, 1, 0);
`else
        run_one("round", 128, 0, 0);
`endif

        write_coef(7, 2047, 2047);
        run_one("clamp_hi", 1792, 2047, 0);
        write_coef(7, -2048, -2048);
        run_one("clamp_lo", 1792, -2048, 0);

        // Backpressure: identity segment, output stalled for the first 5 cycles.
        write_coef(0, 256, 0);
        sent = 0;
        stalled_f = 0;
        for (int cyc = 0; cyc < 40 && got_f.size() < 6; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            if (sent < 6) in_data = bp_x[sent][W-1:0];
            #1;
            if (out_valid && out_ready) begin
                got_f.push_back(int'($signed(f_out)));
                got_s.push_back(int'(sign_out));
            end
            if (cyc == 3) begin
                stalled_f = int'($signed(f_out));
                check("bp_stall_valid", int'(out_valid), 1);
                check("bp_stall_in_ready", int'(in_ready), 0);
            end
            if (cyc == 4) begin
                check("bp_accepted", sent, 3);
                check("bp_in_ready_low", int'(in_ready), 0);
                check("bp_f_stable", int'($signed(f_out)), stalled_f);
            end
            fire_in = in_valid && in_ready;
            @(posedge clk);
            if (fire_in) sent++;
        end
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", got_f.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_f.size()) begin
                check($sformatf("bp_f_%0d", i), got_f[i], 5 + i);
                check($sformatf("bp_sign_%0d", i), got_s[i], i % 2);
            end
        end

        // Reset with two samples in flight.
        write_coef(0, 64, 128);
        @(negedge clk);
        in_valid = 1'b1; in_data = 12'd128;
        @(posedge clk);
        @(negedge clk);
        in_data = -12'sd128;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_f_out", int'(f_out), 0);
        rst = 1'b0;
        ov_count = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) ov_count++;
        end
        check("no_stale_output", ov_count, 0);
        run_one("table_cleared", 128, 0, 0);

        // Write to seg0 in the same cycle the first sample reads it from S2.
        write_coef(0, 64, 128);
        got_f.delete();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1; in_data = 12'd128;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = '0; cfg_slope = 12'd128; cfg_icpt = '0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
        for (int c = 0; c < 10 && got_f.size() < 2; c++) begin
            @(negedge clk);
            if (out_valid) got_f.push_back(int'($signed(f_out)));
        end
        check("hazard_count", got_f.size(), 2);
        if (got_f.size() == 2) begin
            check("hazard_old_coef", got_f[0], 160);
            check("hazard_new_coef", got_f[1], 64);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
